// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, line levels and bit timing
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_LOW  = 1'b0;
  localparam logic LINE_HIGH = 1'b1;

  // Integer truncation only; the residual error is accepted rather than accumulated.
  function automatic int bit_cycles(input int clk_frequency, input int baud_rate);
    return clk_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte handshake between a producer and the UART transmitter
interface uart_transmitter_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tx_data_in;
  logic                  tx_valid_in;
  logic                  tx_ready_out;

  modport master (
    output tx_data_in,
    output tx_valid_in,
    input  tx_ready_out
  );

  modport slave (
    input  tx_data_in,
    input  tx_valid_in,
    output tx_ready_out
  );

endinterface

// File: rtl/uart_baud_tick_generator.sv
// rtl/uart_baud_tick_generator.sv - one-cycle tick every bit period, restartable by clear_in
module uart_baud_tick_generator
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115_200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_in,
  output logic tick_out
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQUENCY, BAUD_RATE);
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIT_CYCLES - 1);

  if (BIT_CYCLES < 2) begin : g_bit_cycles_check
    $error("uart_baud_tick_generator: bit period must be at least 2 clocks");
  end

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear_in) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick_out = (count == LAST_COUNT);

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART serializer: start, LSB-first data, optional parity, stop bits
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_WIDTH    = 8,
  parameter int PARITY_ENABLE = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_transmitter_if.slave tx,
  output logic              uart_tx_out,
  output logic              tx_busy_out
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQUENCY, BAUD_RATE);
  localparam int IDX_W      = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  if (BIT_CYCLES < 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9 ||
      PARITY_ENABLE < 0 || PARITY_ENABLE > 1 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_transmitter: parameter outside legal range");
  end

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      idx_next;
  logic                  tick;
  logic                  parity_bit;

  assign tx.tx_ready_out = (state == IDLE);
  assign tx_busy_out     = (state != IDLE);
  assign idx_next        = bit_idx + IDX_W'(1);
  assign parity_bit      = (^data_q) ^ (PARITY_ODD != 0);

  // Held in clear while idle so every frame starts from a fresh bit period.
  uart_baud_tick_generator #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD_RATE    (BAUD_RATE)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear_in(state == IDLE),
    .tick_out(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      uart_tx_out <= LINE_HIGH;
      bit_idx     <= '0;
      data_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx.tx_valid_in) begin
            data_q      <= tx.tx_data_in;
            bit_idx     <= '0;
            uart_tx_out <= LINE_LOW;
            state       <= START;
          end
        end
        START: begin
          if (tick) begin
            uart_tx_out <= data_q[0];
            bit_idx     <= '0;
            state       <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_ENABLE != 0) begin
                uart_tx_out <= parity_bit;
                state       <= PARITY;
              end else begin
                uart_tx_out <= LINE_HIGH;
                state       <= STOP;
              end
            end else begin
              uart_tx_out <= data_q[idx_next];
              bit_idx     <= idx_next;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            uart_tx_out <= LINE_HIGH;
            state       <= STOP;
          end
        end
        STOP: begin
          // bit_idx counts stop periods here
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              state   <= IDLE;
            end else begin
              bit_idx <= idx_next;
            end
          end
        end
        default: begin
          uart_tx_out <= LINE_HIGH;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter across four parameter sets
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  int         cur;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_transmitter_if #(.DATA_WIDTH(8)) if0 ();
  uart_transmitter_if #(.DATA_WIDTH(8)) if1 ();
  uart_transmitter_if #(.DATA_WIDTH(8)) if2 ();
  uart_transmitter_if #(.DATA_WIDTH(8)) if3 ();

  assign if0.tx_data_in  = tx_data;
  assign if1.tx_data_in  = tx_data;
  assign if2.tx_data_in  = tx_data;
  assign if3.tx_data_in  = tx_data;
  assign if0.tx_valid_in = tx_valid && (cur == 0);
  assign if1.tx_valid_in = tx_valid && (cur == 1);
  assign if2.tx_valid_in = tx_valid && (cur == 2);
  assign if3.tx_valid_in = tx_valid && (cur == 3);

  logic line0, line1, line2, line3;
  logic busy0, busy1, busy2, busy3;

  uart_transmitter dut0 (
    .clk(clk), .rst(rst), .tx(if0), .uart_tx_out(line0), .tx_busy_out(busy0)
  );
  uart_transmitter #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .PARITY_ENABLE(1)) dut1 (
    .clk(clk), .rst(rst), .tx(if1), .uart_tx_out(line1), .tx_busy_out(busy1)
  );
  uart_transmitter #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .PARITY_ENABLE(1),
                     .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .tx(if2), .uart_tx_out(line2), .tx_busy_out(busy2)
  );
  uart_transmitter #(.STOP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .tx(if3), .uart_tx_out(line3), .tx_busy_out(busy3)
  );

  logic line_w, busy_w, ready_w;

  always_comb begin
    line_w  = line0;
    busy_w  = busy0;
    ready_w = if0.tx_ready_out;
    case (cur)
      1: begin line_w = line1; busy_w = busy1; ready_w = if1.tx_ready_out; end
      2: begin line_w = line2; busy_w = busy2; ready_w = if2.tx_ready_out; end
      3: begin line_w = line3; busy_w = busy3; ready_w = if3.tx_ready_out; end
      default: ;
    endcase
  end

  function automatic int bc_of(input int s);
    return (s == 1 || s == 2) ? 10 : 868;
  endfunction

  function automatic bit par_of(input int s);
    return (s == 1 || s == 2);
  endfunction

  function automatic bit odd_of(input int s);
    return (s == 2);
  endfunction

  function automatic int stops_of(input int s);
    return (s == 3) ? 2 : 1;
  endfunction

  task automatic start_tx(input logic [7:0] b, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (ready_w !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (ready_w !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL start_tx_timeout ready=%b required=1", ready_w);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    if (push) exp_q.push_back(b);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Called just after the accepting edge; checks every cycle of the frame.
  task automatic capture_frame(input string name);
    logic [7:0] b;
    logic       exp_bits[12];
    int         nb, bc, at;
    logic       got, bad, sbad, got_busy, got_ready;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard_empty size=0 required>0", name);
      return;
    end
    b  = exp_q.pop_front();
    bc = bc_of(cur);
    nb = 0;
    exp_bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[nb++] = b[i];
    if (par_of(cur)) exp_bits[nb++] = (^b) ^ odd_of(cur);
    for (int i = 0; i < stops_of(cur); i++) exp_bits[nb++] = 1'b1;
    sbad = 1'b0;
    got_busy = 1'b1;
    got_ready = 1'b0;
    for (int p = 0; p < nb; p++) begin
      bad = 1'b0;
      got = 1'b0;
      at  = 0;
      for (int c = 0; c < bc; c++) begin
        @(negedge clk);
        if (!bad && line_w !== exp_bits[p]) begin
          bad = 1'b1;
          got = line_w;
          at  = c;
        end
        if (!sbad && (busy_w !== 1'b1 || ready_w !== 1'b0)) begin
          sbad      = 1'b1;
          got_busy  = busy_w;
          got_ready = ready_w;
        end
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s byte=%h period=%0d cycle=%0d line=%b required=%b",
                 name, b, p, at, got, exp_bits[p]);
      end
    end
    checks++;
    if (sbad) begin
      failures++;
      $display("FAIL %s_status busy=%b ready=%b required busy=1 ready=0", name, got_busy, got_ready);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if ({line_w, ready_w, busy_w} !== 3'b110) begin
      failures++;
      $display("FAIL %s line/ready/busy=%b%b%b required=110", name, line_w, ready_w, busy_w);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    cur      = 0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 4; s++) begin
      cur = s;
      @(negedge clk);
      checks++;
      if (line_w !== 1'b1) begin
        failures++;
        $display("FAIL reset_line dut=%0d line=%b required=1", s, line_w);
      end
      checks++;
      if (ready_w !== 1'b1) begin
        failures++;
        $display("FAIL reset_ready dut=%0d ready=%b required=1", s, ready_w);
      end
      checks++;
      if (busy_w !== 1'b0) begin
        failures++;
        $display("FAIL reset_busy dut=%0d busy=%b required=0", s, busy_w);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur = 0;
  endtask

  task automatic test_basic_frame();
    cur = 0;
    start_tx(8'h55, 1'b1);
    capture_frame("frame_55");
    check_idle("idle_after_55");
  endtask

  task automatic test_parity();
    for (int s = 1; s <= 2; s++) begin
      cur = s;
      start_tx(8'h07, 1'b1);
      capture_frame(s == 1 ? "parity_even_07" : "parity_odd_07");
      check_idle("idle_after_parity_07");
      start_tx(8'hB4, 1'b1);
      capture_frame(s == 1 ? "parity_even_b4" : "parity_odd_b4");
      check_idle("idle_after_parity_b4");
    end
    cur = 0;
  endtask

  task automatic test_back_to_back();
    cur = 0;
    @(negedge clk);
    tx_data  = 8'hA3;
    tx_valid = 1'b1;
    exp_q.push_back(8'hA3);
    @(posedge clk);
    #1;
    tx_data = 8'h3C;
    exp_q.push_back(8'h3C);
    capture_frame("b2b_first");
    @(negedge clk);
    checks++;
    if (ready_w !== 1'b1 || line_w !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap ready=%b line=%b required ready=1 line=1", ready_w, line_w);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    capture_frame("b2b_second");
    check_idle("idle_after_b2b");
  endtask

  task automatic test_reset_mid_frame();
    logic stayed;
    cur = 0;
    start_tx(8'hFF, 1'b0);
    repeat (3 * 868 + 400) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("abort_next_edge");
    stayed = 1'b1;
    for (int c = 0; c < 2 * 868; c++) begin
      @(negedge clk);
      if (line_w !== 1'b1 || busy_w !== 1'b0) stayed = 1'b0;
    end
    checks++;
    if (!stayed) begin
      failures++;
      $display("FAIL abort_no_resume stayed_idle=%b required=1", stayed);
    end
    start_tx(8'h96, 1'b1);
    capture_frame("after_abort_96");
    check_idle("idle_after_abort");
  endtask

  task automatic test_reset_vs_accept();
    logic quiet;
    cur = 0;
    @(negedge clk);
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h12;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    tx_valid = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ({line_w, ready_w, busy_w} !== 3'b110) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL reset_wins_accept dropped=%b required=1", quiet);
    end
  endtask

  task automatic test_random_data(input int s, input int frames);
    cur = s;
    for (int f = 0; f < frames; f++) begin
      start_tx(8'($urandom), 1'b1);
      fork
        capture_frame("random_latch");
        begin
          repeat (9 * bc_of(s)) begin
            @(posedge clk);
            #1;
            tx_data  = 8'($urandom);
            tx_valid = 1'($urandom_range(0, 1));
          end
          tx_valid = 1'b0;
        end
      join
      check_idle("idle_after_random");
    end
    cur = 0;
  endtask

  task automatic test_two_stop_bits();
    cur = 3;
    start_tx(8'h00, 1'b1);
    capture_frame("stop2_00");
    check_idle("idle_after_stop2");
    cur = 0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_vs_accept();
    test_random_data(0, 1);
    test_random_data(1, 4);
    test_two_stop_bits();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLK_FREQUENCY, default 100_000_000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, giving the line bit rate in baud.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, giving data bits per frame (legal range 5..9).
REQ-004 The block SHALL have parameter PARITY_ENABLE, default 0, where 1 inserts one parity bit after the data bits.
REQ-005 The block SHALL have parameter PARITY_ODD, default 0, selecting odd parity when 1 and even parity when 0.
REQ-006 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame (legal values 1 or 2).
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port tx_data_in, input, DATA_WIDTH bits: the byte to send.
REQ-010 The block SHALL have port tx_valid_in, input, 1 bit: tx_data_in is valid.
REQ-011 The block SHALL have port tx_ready_out, output, 1 bit: the block can accept a frame.
REQ-012 The block SHALL have port uart_tx_out, output, 1 bit: the serial line, idle high.
REQ-013 The block SHALL have port tx_busy_out, output, 1 bit: a frame is in progress.

Function
REQ-014 The bit period SHALL be BIT_CYCLES = CLK_FREQUENCY/BAUD_RATE clock cycles, using integer truncation (868 at the defaults), with no fractional accumulation.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with transitions IDLE->START->DATA->(PARITY if PARITY_ENABLE)->STOP->IDLE.
REQ-016 A transfer SHALL be accepted in the cycle where tx_valid_in and tx_ready_out are both high, and tx_data_in SHALL be latched in that cycle.
REQ-017 tx_ready_out SHALL be high only in IDLE, be combinational from the state, and not depend on tx_valid_in.
REQ-018 The start bit (low) SHALL drive uart_tx_out from the cycle after acceptance for exactly BIT_CYCLES cycles.
REQ-019 The data bits SHALL be sent LSB first, each held for exactly BIT_CYCLES cycles, using a bit index counter that runs 0..DATA_WIDTH-1.
REQ-020 The parity bit SHALL be the XOR of the latched data bits, inverted when PARITY_ODD=1, and SHALL be held for BIT_CYCLES cycles.
REQ-021 The stop phase SHALL drive the line high for STOP_BITS*BIT_CYCLES cycles, then the FSM SHALL return to IDLE.
REQ-022 With tx_valid_in held high continuously, the minimum gap between frames SHALL be 1 clk in IDLE, so the next start bit begins 1 cycle after the last stop cycle.
REQ-023 tx_busy_out SHALL be high in every non-IDLE state.
REQ-024 uart_tx_out SHALL be registered, with no combinational path from any input to the line.
REQ-025 The baud counter SHALL restart at 0 on every accept, so a frame never inherits a partial period.
REQ-026 Changes on tx_data_in or tx_valid_in while busy SHALL have no effect on the frame in flight.

Reset
REQ-027 While rst is high at a clock edge: state=IDLE, uart_tx_out=1, tx_ready_out=1, tx_busy_out=0, and the baud and bit counters and data register SHALL be cleared to 0.
REQ-028 A reset during a frame SHALL abort it, drive the line high from the next edge, and the aborted byte SHALL not be resumed.
REQ-029 rst asserted in the same cycle as an accept SHALL win, and the byte SHALL be dropped.

Structure
REQ-030 A shared package uart_pkg SHALL hold the state encodings, the LOW/HIGH line constants and the BIT_CYCLES computation; uart_receiver SHALL reuse it.
REQ-031 Sub-module uart_baud_tick_generator (parameters CLK_FREQUENCY and BAUD_RATE; ports clk, rst, clear_in, tick_out) SHALL pulse tick_out for 1 cycle every BIT_CYCLES cycles after clear_in.
REQ-032 A synthesis-time check SHALL fail if BIT_CYCLES < 2 or if a parameter is outside its legal range.

Verification
REQ-033 Defaults, send 0x55: line low 868 cycles, then bits 1,0,1,0,1,0,1,0 at 868 cycles each, then high 868 cycles; total frame 8680 cycles.
REQ-034 PARITY_ENABLE=1, PARITY_ODD=0, send 0x07: parity bit = 1 in a frame of 11 bits; with PARITY_ODD=1, parity bit = 0.
REQ-035 tx_valid_in held high with data 0xA3 then 0x3C: two frames, a 1-cycle idle gap between them, and tx_ready_out high for exactly 1 cycle.
REQ-036 rst pulsed for 1 cycle at the third data bit of a 0xFF frame: line high on the next edge, tx_busy_out=0, and the next frame sent intact.
REQ-037 STOP_BITS=2, send 0x00: 9 low bit periods, then high for 1736 cycles before tx_ready_out rises.
REQ-038 Drive tx_data_in with random values during a frame: the serialized byte SHALL equal the value latched at accept.
